entry_controller: RTL
=====================

ENTRY_CONTROLLER -- requirements
Module: entry_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, giving the number of stable clk cycles required to accept a button level.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-004 The block SHALL have port btn_next, input, 1 bit, raw asynchronous advance button.
REQ-005 The block SHALL have port btn_back, input, 1 bit, raw asynchronous step-back button.
REQ-006 The block SHALL have port sw, input, 5 bits: sw[3:0] is the operand value and sw[4] is the operation select (1 = subtract).
REQ-007 The block SHALL have port en1, output, 1 bit, high while entering operand A.
REQ-008 The block SHALL have port en2, output, 1 bit, high while entering operand B.
REQ-009 The block SHALL have port en3, output, 1 bit, high while the result is shown.
REQ-010 The block SHALL have port operand_a, output, 6 bits, operand A register.
REQ-011 The block SHALL have port operand_b, output, 6 bits, operand B register.
REQ-012 The block SHALL have port op_sub, output, 1 bit, latched operation select.
REQ-013 The block SHALL have port commit, output, 1 bit, one-cycle strobe on entry to SHOW_RESULT.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debounce counter; the filtered level changes only after DEBOUNCE_CYCLES consecutive cycles of a differing synchronized level, and the counter clears whenever the level matches the filtered level.
REQ-015 A press event SHALL be a single-cycle pulse on the rising edge of the filtered level; holding a button SHALL produce exactly one event.
REQ-016 The FSM SHALL have states ENTER_A, ENTER_B and SHOW_RESULT, with exactly one of en1/en2/en3 high, matching the state.
REQ-017 In ENTER_A, operand_a SHALL load {2'b00, sw[3:0]} every cycle; in ENTER_B, operand_b SHALL do the same; in all other states both SHALL hold their values.
REQ-018 A next event SHALL cause ENTER_A->ENTER_B, ENTER_B->SHOW_RESULT, and SHOW_RESULT->ENTER_A.
REQ-019 On ENTER_B->SHOW_RESULT, op_sub SHALL load sw[4] and commit SHALL be high for exactly the following cycle.
REQ-020 op_sub SHALL hold its value outside that transition, so sw[4] changes during SHOW_RESULT have no effect.
REQ-021 On SHOW_RESULT->ENTER_A, operand_b SHALL clear to 0.
REQ-022 A back event SHALL cause ENTER_B->ENTER_A, keeping operand_b, and SHOW_RESULT->ENTER_B; in ENTER_A, back SHALL be ignored.
REQ-023 If next and back events occur in the same cycle, back SHALL win and next SHALL be discarded.
REQ-024 The transition latency SHALL be one clk cycle after the press-event pulse.

Reset
REQ-025 Reset SHALL asynchronously force state ENTER_A, en1=1, en2=0, en3=0, operand_a=0, operand_b=0, op_sub=0 and commit=0.
REQ-026 Reset SHALL clear the synchronizers, debounce counters and filtered levels to 0, so a button held through reset release produces no event until it is released and pressed again.
REQ-027 Reset asserted mid-debounce or mid-commit SHALL abort the operation with no residual pulse.

Structure
REQ-028 A shared package calc_pkg SHALL hold the state enum typedef (ENTER_A, ENTER_B, SHOW_RESULT), the operand width constant OPERAND_W=6 and the switch-input width constant SW_IN_W=4.
REQ-029 Debouncing SHALL be one sub-module, button_debounce (synchronizer, counter, edge pulse), instantiated twice.

Verification
REQ-030 Bench SHALL use DEBOUNCE_CYCLES=4; bouncing btn_next (toggling every cycle for 10 cycles, then high) -> exactly one next event and ENTER_A->ENTER_B.
REQ-031 Bench SHALL apply sw=5'b0_0011, next, sw=5'b1_0101, next -> operand_a=3, operand_b=5, op_sub=1, en3=1, and one commit pulse.
REQ-032 Bench SHALL change sw to 5'b0_1111 in SHOW_RESULT -> operand_a, operand_b and op_sub are unchanged.
REQ-033 Bench SHALL apply back in SHOW_RESULT, then back, then next -> ENTER_B, then ENTER_A, then ENTER_B; back in ENTER_A -> no state change.
REQ-034 Bench SHALL create simultaneous next and back events in ENTER_B -> state becomes ENTER_A.
REQ-035 Bench SHALL assert reset mid-entry, asynchronous to clk, with btn_next held -> outputs reach reset values immediately, and no event occurs until btn_next is released and re-pressed.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and widths for the entry controller and its helpers.
package calc_pkg;

  localparam int OPERAND_W = 6;
  localparam int SW_IN_W   = 4;

  typedef enum logic [1:0] {
    ENTER_A     = 2'd0,
    ENTER_B     = 2'd1,
    SHOW_RESULT = 2'd2
  } state_t;

  // Widen a raw switch nibble to the operand register width.
  function automatic logic [OPERAND_W-1:0] zero_extend_sw(input logic [SW_IN_W-1:0] value);
    return {{(OPERAND_W - SW_IN_W){1'b0}}, value};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Button conditioner: two-flop synchronizer, stable-level debounce counter
// and a single-cycle press pulse on the rising edge of the filtered level.
// A button held through reset release is ignored until it has been seen
// released, so no spurious press comes out of reset.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  // The counter runs 0..DEBOUNCE_CYCLES-1; the last count accepts the level.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;
  logic [1:0]       fill_q, fill_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;

  // Next-state logic: synchronizer shift, debounce count, arming and edge pulse.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    fill_d  = {fill_q[0], 1'b1};
    cnt_d   = '0;
    filt_d  = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // fill_q[1] marks the point where sync2_q reflects the real pin again,
    // so the zeros left behind by reset cannot arm the press detector.
    armed_d = armed_q | (fill_q[1] & ~sync2_q);
    press_d = filt_d & ~filt_q & armed_q;
  end

  // Register all conditioner state; reset returns everything to idle-low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/entry_controller.sv
// Operand entry sequencer for a two-operand calculator: steps through
// ENTER_A, ENTER_B and SHOW_RESULT on debounced next/back buttons,
// capturing switch values and the add/subtract select along the way.
module entry_controller
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_next,
  input  logic                 btn_back,
  input  logic [SW_IN_W:0]     sw,
  output logic                 en1,
  output logic                 en2,
  output logic                 en3,
  output logic [OPERAND_W-1:0] operand_a,
  output logic [OPERAND_W-1:0] operand_b,
  output logic                 op_sub,
  output logic                 commit
);

  logic next_evt;
  logic back_evt;

  state_t               state_q, state_d;
  logic [OPERAND_W-1:0] operand_a_q, operand_a_d;
  logic [OPERAND_W-1:0] operand_b_q, operand_b_d;
  logic                 op_sub_q, op_sub_d;
  logic                 commit_q, commit_d;
  logic                 en1_q, en1_d;
  logic                 en2_q, en2_d;
  logic                 en3_q, en3_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_next),
    .press  (next_evt)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_back_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_back),
    .press  (back_evt)
  );

  // Sequencer next-state: back has priority over next in every state.
  always_comb begin
    state_d     = state_q;
    operand_a_d = operand_a_q;
    operand_b_d = operand_b_q;
    op_sub_d    = op_sub_q;
    commit_d    = 1'b0;
    case (state_q)
      ENTER_A: begin
        operand_a_d = zero_extend_sw(sw[SW_IN_W-1:0]);
        if (next_evt && !back_evt) begin
          state_d = ENTER_B;
        end
      end
      ENTER_B: begin
        operand_b_d = zero_extend_sw(sw[SW_IN_W-1:0]);
        if (back_evt) begin
          state_d = ENTER_A;
        end else if (next_evt) begin
          state_d  = SHOW_RESULT;
          op_sub_d = sw[SW_IN_W];
          commit_d = 1'b1;
        end
      end
      SHOW_RESULT: begin
        if (back_evt) begin
          state_d = ENTER_B;
        end else if (next_evt) begin
          state_d     = ENTER_A;
          operand_b_d = '0;
        end
      end
      default: begin
        state_d = ENTER_A;
      end
    endcase
    en1_d = (state_d == ENTER_A);
    en2_d = (state_d == ENTER_B);
    en3_d = (state_d == SHOW_RESULT);
  end

  // Register the state together with all outputs so they switch in one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ENTER_A;
      operand_a_q <= '0;
      operand_b_q <= '0;
      op_sub_q    <= 1'b0;
      commit_q    <= 1'b0;
      en1_q       <= 1'b1;
      en2_q       <= 1'b0;
      en3_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      operand_a_q <= operand_a_d;
      operand_b_q <= operand_b_d;
      op_sub_q    <= op_sub_d;
      commit_q    <= commit_d;
      en1_q       <= en1_d;
      en2_q       <= en2_d;
      en3_q       <= en3_d;
    end
  end

  assign en1       = en1_q;
  assign en2       = en2_q;
  assign en3       = en3_q;
  assign operand_a = operand_a_q;
  assign operand_b = operand_b_q;
  assign op_sub    = op_sub_q;
  assign commit    = commit_q;

endmodule
